// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
// Build option: define SPI_SLAVE_PARITY_EN to append an even-parity bit to every frame.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_t;

`ifdef SPI_SLAVE_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  // Wide enough for the longest frame count, including an optional parity bit.
  function automatic int unsigned spi_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 4);
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO shifter: loads one read word, then emits it bit by bit (plus parity
// when SPI_SLAVE_PARITY_EN is defined), idling at 0.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              clr,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              active,
  output logic              done
);

  localparam int SR_W   = DATA_W + int'(PAR_W);
  localparam int BCNT_W = spi_cnt_w(DATA_W);

  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   load_word;
  logic [BCNT_W-1:0] bits;

  always_comb begin
`ifdef SPI_SLAVE_PARITY_EN
    load_word = LSB_FIRST ? {^data, data} : {data, ^data};
`else
    load_word = data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr     <= '0;
      bits   <= '0;
      active <= 1'b0;
    end else if (load) begin
      sr     <= load_word;
      bits   <= BCNT_W'(SR_W);
      active <= 1'b1;
    end else if (active && shift) begin
      sr   <= LSB_FIRST ? (sr >> 1) : (sr << 1);
      bits <= bits - 1'b1;
      if (bits == BCNT_W'(1)) active <= 1'b0;
    end
  end

  assign miso = active & (LSB_FIRST ? sr[0] : sr[SR_W-1]);
  assign done = active && shift && !clr && (bits == BCNT_W'(1));

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end for the RAM subsystem: rw bit + DATA_W+2 bit frames in,
// read data out on MISO. Build option SPI_SLAVE_PARITY_EN adds per-frame parity.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FRAME_W + int'(PAR_W));

  spi_state_t         state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_q, frame_shift, frame_word;
  logic               rd_pending, rd_wait;
  logic               shift_en, frame_done, par_fail, abort, ser_load;
  logic               ser_active, ser_done;

  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    frame_done  = 1'b0;
    par_fail    = 1'b0;
    abort       = 1'b0;
    ser_load    = 1'b0;
    frame_shift = LSB_FIRST ? {MOSI, frame_q[FRAME_W-1:1]} : {frame_q[FRAME_W-2:0], MOSI};
`ifdef SPI_SLAVE_PARITY_EN
    frame_word  = frame_q;
`else
    frame_word  = frame_shift;
`endif
    case (state)
      IDLE: if (!SS_n) state_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)            state_next = IDLE;
        else if (!MOSI)      state_next = WRITE;
        else if (rd_pending) state_next = READ_DATA;
        else                 state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_next = IDLE;
          abort      = (cnt != '0) || ser_active;
        end else if (cnt != '0) begin
`ifdef SPI_SLAVE_PARITY_EN
          // Final bit is parity over the payload; it is checked, not stored.
          if (cnt == CNT_W'(1)) begin
            frame_done = (MOSI == ^frame_q[DATA_W-1:0]);
            par_fail   = !frame_done;
          end else begin
            shift_en = 1'b1;
          end
`else
          shift_en   = 1'b1;
          frame_done = (cnt == CNT_W'(1));
`endif
        end else if (state == READ_DATA && rd_wait && tx_valid) begin
          ser_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rd_pending <= 1'b0;
      rd_wait    <= 1'b0;
    end else begin
      state     <= state_next;
      rx_valid  <= frame_done;
      frame_err <= abort | par_fail;
      if (state == CHK_CMD) begin
        cnt     <= CNT_INIT;
        rd_wait <= 1'b0;
      end else if (shift_en || frame_done || par_fail) begin
        cnt <= cnt - 1'b1;
      end
      if (shift_en) frame_q <= frame_shift;
      if (frame_done) begin
        rx_data <= frame_word;
        if (state == READ_ADD)  rd_pending <= 1'b1;
        if (state == READ_DATA) rd_wait    <= 1'b1;
      end
      if (ser_load) rd_wait    <= 1'b0;
      if (ser_done) rd_pending <= 1'b0;
    end
  end

  spi_tx_serializer #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ser_load),
    .shift  (!SS_n),
    .clr    (abort),
    .data   (tx_data),
    .miso   (MISO),
    .active (ser_active),
    .done   (ser_done)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an 8-bit MSB-first instance and a
// 16-bit LSB-first instance driven from one linear stimulus sequence.
module tb_spi_slave_param;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n, mosi, miso, rx_valid, tx_valid, busy, frame_err;
  logic [9:0]  rx_data;
  logic [7:0]  tx_data;
  logic        ss16, mosi16, miso16, rx_valid16, tx_valid16, busy16, frame_err16;
  logic [17:0] rx_data16;
  logic [15:0] tx_data16;

  int checks = 0, errors = 0;
  int rxv_cnt = 0, ferr_cnt = 0;
  int rxv0, ferr0;
  logic [9:0]  frm;
  logic [17:0] frm16;
  logic [7:0]  exp_tx;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt++;
    if (frame_err) ferr_cnt++;
  end

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .frame_err(frame_err)
  );

  spi_slave_param #(.DATA_W(16), .LSB_FIRST(1'b1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16), .tx_valid(tx_valid16),
    .busy(busy16), .frame_err(frame_err16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic m);
    ss_n = s;
    mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic step16(input logic s, input logic m);
    ss16   = s;
    mosi16 = m;
    @(posedge clk);
    #1;
  endtask

  // Select, rw bit, frame MSB first, then the parity bit in parity builds.
  task automatic send8(input logic rw, input logic [9:0] frame);
    step(1'b0, 1'b0);
    step(1'b0, rw);
    for (int i = 9; i >= 0; i--) step(1'b0, frame[i]);
`ifdef SPI_SLAVE_PARITY_EN
    step(1'b0, ^frame[7:0]);
`endif
  endtask

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    ss16 = 1'b1; mosi16 = 1'b0; tx_valid16 = 1'b0; tx_data16 = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_miso", miso, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_state", u_dut.state, IDLE);
    chk("rst_rd_pending", u_dut.rd_pending, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("idle_busy", busy, 0);

    // Write frame 00_1010_0101
    rxv0 = rxv_cnt;
    frm  = {CMD_WR_ADDR, 8'hA5};
    step(1'b0, 1'b0);
    chk("wr_busy_c1", busy, 1);
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) step(1'b0, frm[i]);
`ifdef SPI_SLAVE_PARITY_EN
    step(1'b0, ^frm[7:0]);
`endif
    chk("wr_rx_valid", rx_valid, 1);
    chk("wr_rx_data", rx_data, 10'h0A5);
    step(1'b0, 1'b1);
    chk("wr_rx_valid_pulse", rx_valid, 0);
    chk("wr_busy_hold", busy, 1);
    step(1'b1, 1'b0);
    chk("wr_busy_end", busy, 0);
    chk("wr_rxv_count", rxv_cnt - rxv0, 1);

    // Read address; tx_valid held high must be ignored here
    tx_valid = 1'b1; tx_data = 8'hFF;
    send8(1'b1, 10'h233);
    chk("ra_rx_valid", rx_valid, 1);
    chk("ra_rx_data", rx_data, 10'h233);
    chk("ra_rd_pending", u_dut.rd_pending, 1);
    step(1'b0, 1'b0);
    chk("ra_miso_idle", miso, 0);
    tx_valid = 1'b0; tx_data = '0;
    step(1'b1, 1'b0);
    chk("ra_pending_kept", u_dut.rd_pending, 1);

    // Read data; tx_valid three cycles after rx_valid
    send8(1'b1, 10'h300);
    chk("rd_rx_valid", rx_valid, 1);
    chk("rd_rx_data", rx_data, 10'h300);
    chk("rd_state", u_dut.state, READ_DATA);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rd_miso_wait", miso, 0);
    tx_data = 8'hC3; tx_valid = 1'b1;
    step(1'b0, 1'b0);
    tx_valid = 1'b0; tx_data = '0;
    exp_tx = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("rd_miso_b%0d", i), miso, exp_tx[i]);
      step(1'b0, 1'b0);
    end
`ifdef SPI_SLAVE_PARITY_EN
    chk("rd_miso_par", miso, ^exp_tx);
    step(1'b0, 1'b0);
`endif
    chk("rd_miso_after", miso, 0);
    chk("rd_pending_clr", u_dut.rd_pending, 0);
    step(1'b1, 1'b0);

    // Abort a write after 5 data bits
    rxv0 = rxv_cnt; ferr0 = ferr_cnt;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("ab_frame_err", frame_err, 1);
    chk("ab_state", u_dut.state, IDLE);
    chk("ab_rx_data", rx_data, 10'h300);
    step(1'b1, 1'b0);
    chk("ab_frame_err_pulse", frame_err, 0);
    chk("ab_ferr_count", ferr_cnt - ferr0, 1);
    chk("ab_rxv_count", rxv_cnt - rxv0, 0);

    // Abort during MISO shifting keeps the read pending
    send8(1'b1, 10'h233);
    step(1'b1, 1'b0);
    send8(1'b1, 10'h300);
    tx_data = 8'h5A; tx_valid = 1'b1;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("mab_frame_err", frame_err, 1);
    chk("mab_miso", miso, 0);
    chk("mab_rd_pending", u_dut.rd_pending, 1);

    // Retry goes straight to READ_DATA; reset mid-shift
    send8(1'b1, 10'h300);
    chk("retry_state", u_dut.state, READ_DATA);
    tx_valid = 1'b1;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    chk("retry_miso_b7", miso, 0);
    step(1'b0, 1'b0);
    chk("retry_miso_b6", miso, 1);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    chk("mrst_miso", miso, 0);
    chk("mrst_rd_pending", u_dut.rd_pending, 0);
    chk("mrst_state", u_dut.state, IDLE);
    chk("mrst_busy", busy, 0);
    rst_n = 1'b1; tx_data = '0;
    step(1'b1, 1'b0);

`ifdef SPI_SLAVE_PARITY_EN
    // Parity: wrong bit then correct bit for frame 01_1111_0000
    frm = 10'h1F0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) step(1'b0, frm[i]);
    step(1'b0, ~(^frm[7:0]));
    chk("par_bad_ferr", frame_err, 1);
    chk("par_bad_rxv", rx_valid, 0);
    step(1'b1, 1'b0);
    send8(1'b0, frm);
    chk("par_ok_rxv", rx_valid, 1);
    chk("par_ok_rx_data", rx_data, 10'h1F0);
    step(1'b1, 1'b0);
`endif

    // 16-bit LSB-first write of payload 16'h8001
    frm16 = {CMD_WR_DATA, 16'h8001};
    step16(1'b0, 1'b0);
    step16(1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("w16_no_early_rxv_%0d", i), rx_valid16, 0);
      step16(1'b0, frm16[i]);
    end
`ifdef SPI_SLAVE_PARITY_EN
    step16(1'b0, ^frm16[15:0]);
`endif
    chk("w16_rx_valid", rx_valid16, 1);
    chk("w16_rx_data", rx_data16, 18'h18001);
    chk("w16_payload", rx_data16[15:0], 16'h8001);
    step16(1'b1, 1'b0);
    chk("w16_rx_valid_pulse", rx_valid16, 0);
    chk("w16_miso", miso16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
